// File: rtl/pc_fetch.sv
// pc_fetch: program-counter and instruction-fetch front end.
// Drives a synchronous program ROM and handles jumps, calls, returns and
// skips through a 2-entry return stack. Stall holds the presented word.
// Every redirect costs one bubble.
module pc_fetch #(
    parameter logic [10:0] RESET_VECTOR = 11'h7FF,
    parameter logic [11:0] NOP_WORD     = 12'h000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        jmp_en,
    input  logic [10:0] jmp_addr,
    input  logic        call_en,
    input  logic        ret_en,
    input  logic        skip,
    output logic [10:0] rom_addr,
    input  logic [11:0] rom_data,
    output logic [11:0] instr,
    output logic        instr_valid,
    output logic [10:0] pc_out,
    output logic        stack_ovf,
    output logic        stack_unf
);

    typedef enum logic [2:0] {
        RD_NONE,
        RD_RET,
        RD_CALL,
        RD_JMP,
        RD_SKIP
    } redir_t;

    redir_t      redir;
    logic [10:0] s0;
    logic [10:0] s1;
    logic [1:0]  depth;
    logic        hold_valid;
    logic [11:0] hold_reg;
    logic [10:0] ret_addr;

    assign ret_addr = pc_out + 11'd1;

    // Pick the winning redirect; only a valid presented instruction may redirect.
    always_comb begin
        redir = RD_NONE;
        if (instr_valid) begin
            if (ret_en)       redir = RD_RET;
            else if (call_en) redir = RD_CALL;
            else if (jmp_en)  redir = RD_JMP;
            else if (skip)    redir = RD_SKIP;
        end
    end

    // Presented word: the held copy while stalled, otherwise the ROM output or a bubble.
    always_comb begin
        if (hold_valid)       instr = hold_reg;
        else if (instr_valid) instr = rom_data;
        else                  instr = NOP_WORD;
    end

    // Fetch pointer, return stack and sticky flags.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rom_addr    <= RESET_VECTOR;
            pc_out      <= RESET_VECTOR;
            instr_valid <= 1'b0;
            s0          <= 11'd0;
            s1          <= 11'd0;
            depth       <= 2'd0;
            hold_valid  <= 1'b0;
            hold_reg    <= NOP_WORD;
            stack_ovf   <= 1'b0;
            stack_unf   <= 1'b0;
        end else if (stall) begin
            // rom_data moves on to the next word after one edge, so capture the current one.
            if (!hold_valid) begin
                hold_reg   <= instr;
                hold_valid <= 1'b1;
            end
        end else begin
            hold_valid <= 1'b0;
            case (redir)
                RD_RET: begin
                    rom_addr    <= s0;
                    instr_valid <= 1'b0;
                    s0          <= s1;
                    if (depth == 2'd0) stack_unf <= 1'b1;
                    else               depth     <= depth - 2'd1;
                end
                RD_CALL: begin
                    rom_addr    <= jmp_addr;
                    instr_valid <= 1'b0;
                    s1          <= s0;
                    s0          <= ret_addr;
                    if (depth == 2'd2) stack_ovf <= 1'b1;
                    else               depth     <= depth + 2'd1;
                end
                RD_JMP: begin
                    rom_addr    <= jmp_addr;
                    instr_valid <= 1'b0;
                end
                RD_SKIP: begin
                    // The word already in flight is the skipped one; fetch past it.
                    rom_addr    <= rom_addr + 11'd1;
                    instr_valid <= 1'b0;
                end
                default: begin
                    pc_out      <= rom_addr;
                    rom_addr    <= rom_addr + 11'd1;
                    instr_valid <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pc_fetch.sv
// Testbench for pc_fetch: a program-level reference model predicts the presented
// instruction stream; a monitor compares the queued expectations against the DUT.
module tb_pc_fetch;

    localparam logic [11:0] NOP = 12'h000;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        stall = 1'b0;
    logic        jmp_en = 1'b0;
    logic [10:0] jmp_addr = 11'd0;
    logic        call_en = 1'b0;
    logic        ret_en = 1'b0;
    logic        skip = 1'b0;
    logic [10:0] rom_addr;
    logic [11:0] rom_data;
    logic [11:0] instr;
    logic        instr_valid;
    logic [10:0] pc_out;
    logic        stack_ovf;
    logic        stack_unf;

    int n_checks = 0;
    int n_fail = 0;

    logic [11:0] mem [0:2047];

    typedef struct packed {
        logic        v;
        logic [10:0] pc;
        logic [11:0] ins;
        logic        ovf;
        logic        unf;
    } exp_t;
    exp_t exp_q[$];

    // Program-level model: the address being presented, the address that will
    // be presented next, and the return stack.
    logic        m_valid;
    logic [10:0] m_pc;
    logic [10:0] m_next;
    logic [10:0] m_stk [0:1];
    int          m_depth;
    logic        m_ovf;
    logic        m_unf;

    pc_fetch dut (
        .clk(clk), .rst(rst), .stall(stall), .jmp_en(jmp_en), .jmp_addr(jmp_addr),
        .call_en(call_en), .ret_en(ret_en), .skip(skip), .rom_addr(rom_addr),
        .rom_data(rom_data), .instr(instr), .instr_valid(instr_valid),
        .pc_out(pc_out), .stack_ovf(stack_ovf), .stack_unf(stack_unf)
    );

    always #5 clk = ~clk;

    always @(posedge clk) rom_data <= mem[rom_addr];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h, required %0h", name, act, req);
        end
    endtask

    task automatic model_reset();
        m_valid = 1'b0;
        m_pc = 11'h7FF;
        m_next = 11'h7FF;
        m_stk[0] = 11'd0;
        m_stk[1] = 11'd0;
        m_depth = 0;
        m_ovf = 1'b0;
        m_unf = 1'b0;
    endtask

    task automatic model_update(input logic st, input logic r, input logic c,
                                input logic j, input logic sk, input logic [10:0] a);
        exp_t e;
        if (!st) begin
            if (m_valid && r) begin
                m_next = m_stk[0];
                m_stk[0] = m_stk[1];
                if (m_depth == 0) m_unf = 1'b1;
                else m_depth--;
                m_valid = 1'b0;
            end else if (m_valid && c) begin
                m_stk[1] = m_stk[0];
                m_stk[0] = m_pc + 11'd1;
                if (m_depth == 2) m_ovf = 1'b1;
                else m_depth++;
                m_next = a;
                m_valid = 1'b0;
            end else if (m_valid && j) begin
                m_next = a;
                m_valid = 1'b0;
            end else if (m_valid && sk) begin
                m_next = m_next + 11'd1;
                m_valid = 1'b0;
            end else begin
                m_pc = m_next;
                m_next = m_next + 11'd1;
                m_valid = 1'b1;
            end
        end
        e.v = m_valid;
        e.pc = m_pc;
        e.ins = m_valid ? mem[m_pc] : NOP;
        e.ovf = m_ovf;
        e.unf = m_unf;
        exp_q.push_back(e);
    endtask

    task automatic step(input logic st, input logic r, input logic c,
                        input logic j, input logic sk, input logic [10:0] a);
        @(negedge clk);
        stall = st; ret_en = r; call_en = c; jmp_en = j; skip = sk; jmp_addr = a;
        model_update(st, r, c, j, sk, a);
    endtask

    task automatic run_until(input logic [10:0] target);
        int n = 0;
        while (!(m_valid && m_pc == target) && n < 4096) begin
            step(0, 0, 0, 0, 0, 11'd0);
            n++;
        end
        if (n >= 4096) begin
            n_checks++;
            n_fail++;
            $display("FAIL run_until timeout: pc %0h, required %0h", m_pc, target);
        end
    endtask

    task automatic expect_now(input string name, input logic v, input logic [10:0] pc,
                              input logic [11:0] ins);
        @(posedge clk);
        #2;
        chk({name, "_valid"}, 32'(instr_valid), 32'(v));
        chk({name, "_instr"}, 32'(instr), 32'(ins));
        if (v) chk({name, "_pc"}, 32'(pc_out), 32'(pc));
    endtask

    task automatic do_reset(input bit rnd_mem);
        @(negedge clk);
        rst = 1'b1;
        stall = 0; ret_en = 0; call_en = 0; jmp_en = 0; skip = 0; jmp_addr = 11'd0;
        exp_q.delete();
        #1;
        chk("rst_rom_addr", 32'(rom_addr), 32'h7FF);
        chk("rst_pc_out", 32'(pc_out), 32'h7FF);
        chk("rst_valid", 32'(instr_valid), 32'd0);
        chk("rst_instr", 32'(instr), 32'(NOP));
        chk("rst_ovf", 32'(stack_ovf), 32'd0);
        chk("rst_unf", 32'(stack_unf), 32'd0);
        if (rnd_mem) for (int i = 0; i < 2048; i++) mem[i] = 12'($urandom);
        repeat (2) @(negedge clk);
        model_reset();
        rst = 1'b0;
        model_update(0, 0, 0, 0, 0, 11'd0);
    endtask

    // Monitor: one expectation per clock edge, compared just after the edge.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("mon_valid", 32'(instr_valid), 32'(e.v));
                chk("mon_instr", 32'(instr), 32'(e.ins));
                chk("mon_pc", 32'(pc_out), 32'(e.pc));
                chk("mon_ovf", 32'(stack_ovf), 32'(e.ovf));
                chk("mon_unf", 32'(stack_unf), 32'(e.unf));
            end
        end
    end

    initial begin
        for (int i = 0; i < 2048; i++) mem[i] = 12'(i + 1);
        model_reset();
        repeat (2) @(negedge clk);

        // Reset release sequence
        do_reset(0);
        expect_now("rel0", 1, 11'h7FF, 12'h800);
        step(0, 0, 0, 0, 0, 11'd0);
        expect_now("rel1", 1, 11'h000, 12'h001);
        step(0, 0, 0, 0, 0, 11'd0);
        expect_now("rel2", 1, 11'h001, 12'h002);

        // Absolute jump
        run_until(11'h005);
        step(0, 0, 0, 1, 0, 11'h123);
        expect_now("jmp_bub", 0, 11'h000, NOP);
        step(0, 0, 0, 0, 0, 11'd0);
        expect_now("jmp_tgt", 1, 11'h123, 12'h124);

        // Call and return
        do_reset(0);
        run_until(11'h010);
        step(0, 0, 1, 0, 0, 11'h200);
        expect_now("call_bub", 0, 11'h000, NOP);
        step(0, 0, 0, 0, 0, 11'd0);
        expect_now("call_tgt", 1, 11'h200, 12'h201);
        step(0, 1, 0, 0, 0, 11'd0);
        expect_now("ret_bub", 0, 11'h000, NOP);
        step(0, 0, 0, 0, 0, 11'd0);
        expect_now("ret_tgt", 1, 11'h011, 12'h012);

        // Nested calls overflow, returns underflow
        do_reset(0);
        run_until(11'h040);
        step(0, 0, 1, 0, 0, 11'h100);
        step(0, 0, 0, 0, 0, 11'd0);
        step(0, 0, 1, 0, 0, 11'h180);
        step(0, 0, 0, 0, 0, 11'd0);
        step(0, 0, 1, 0, 0, 11'h1C0);
        expect_now("call3_bub", 0, 11'h000, NOP);
        chk("ovf_after_call3", 32'(stack_ovf), 32'd1);
        step(0, 0, 0, 0, 0, 11'd0);
        step(0, 1, 0, 0, 0, 11'd0);
        step(0, 0, 0, 0, 0, 11'd0);
        expect_now("ret1_tgt", 1, 11'h181, 12'h182);
        step(0, 1, 0, 0, 0, 11'd0);
        step(0, 0, 0, 0, 0, 11'd0);
        expect_now("ret2_tgt", 1, 11'h101, 12'h102);
        chk("unf_before_ret3", 32'(stack_unf), 32'd0);
        step(0, 1, 0, 0, 0, 11'd0);
        step(0, 0, 0, 0, 0, 11'd0);
        expect_now("ret3_tgt", 1, 11'h101, 12'h102);
        chk("unf_after_ret3", 32'(stack_unf), 32'd1);

        // Skip, then stall for three cycles
        do_reset(0);
        run_until(11'h020);
        step(0, 0, 0, 0, 1, 11'd0);
        expect_now("skip_bub", 0, 11'h000, NOP);
        step(0, 0, 0, 0, 0, 11'd0);
        expect_now("skip_tgt", 1, 11'h022, 12'h023);
        run_until(11'h030);
        for (int i = 0; i < 3; i++) begin
            step(1, 0, 0, 1, 0, 11'h3AA);
            expect_now("stall_hold", 1, 11'h030, 12'h031);
        end
        step(0, 0, 0, 0, 0, 11'd0);
        expect_now("stall_rel", 1, 11'h031, 12'h032);

        // Reset during a stall and during a bubble
        run_until(11'h050);
        step(1, 0, 0, 0, 0, 11'd0);
        step(1, 0, 0, 0, 0, 11'd0);
        do_reset(0);
        expect_now("rst_stall_restart", 1, 11'h7FF, 12'h800);
        run_until(11'h060);
        step(0, 0, 0, 1, 0, 11'h300);
        do_reset(0);
        expect_now("rst_bub_restart", 1, 11'h7FF, 12'h800);

        // Randomized program flow with random ROM contents
        do_reset(1);
        for (int i = 0; i < 3000; i++) begin
            logic st, r, c, j, sk;
            st = ($urandom_range(0, 4) == 0);
            r  = ($urandom_range(0, 7) == 0);
            c  = ($urandom_range(0, 7) == 0);
            j  = ($urandom_range(0, 7) == 0);
            sk = ($urandom_range(0, 7) == 0);
            step(st, r, c, j, sk, 11'($urandom));
        end
        step(0, 0, 0, 0, 0, 11'd0);
        repeat (3) @(negedge clk);
        chk("queue_drained", 32'(exp_q.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/pc_fetch.md
PC_FETCH -- requirements
Module: pc_fetch

Interface
REQ-001 Parameter RESET_VECTOR, default 11'h7FF, is the first fetch address after reset.
REQ-002 Parameter NOP_WORD, default 12'h000, is the instruction word presented during bubbles.
REQ-003 Port clk  in  1  is the single clock; every register updates on its rising edge.
REQ-004 Port rst  in  1  is the reset; it is asynchronous and active-high.
REQ-005 Port stall  in  1  freezes fetch and holds the presented instruction.
REQ-006 Port jmp_en  in  1 and port jmp_addr  in  11  request an absolute jump to jmp_addr.
REQ-007 Port call_en  in  1  requests a jump to jmp_addr plus a push of the return address.
REQ-008 Port ret_en  in  1  requests a jump to the stack top plus a pop.
REQ-009 Port skip  in  1  discards the next sequential instruction.
REQ-010 Port rom_addr  out  11  is the registered fetch address to the program ROM.
REQ-011 Port rom_data  in  12  is the ROM word, valid one cycle after rom_addr.
REQ-012 Port instr  out  12  is the instruction presented to decode.
REQ-013 Port instr_valid  out  1  qualifies instr; instr equals NOP_WORD whenever instr_valid=0.
REQ-014 Port pc_out  out  11  is the address of the presented instr.
REQ-015 Ports stack_ovf  out  1 and stack_unf  out  1  are sticky error flags.

Function
REQ-016 The ROM read is synchronous: rom_data in cycle n+1 = mem[rom_addr in cycle n].
REQ-017 Sequential advance, when stall=0 and no redirect: pc_out<=rom_addr; rom_addr<=rom_addr+1 mod 2048 (11'h7FF wraps to 11'h000); instr_valid<=1.
REQ-018 instr = hold_valid ? hold_reg : (instr_valid ? rom_data : NOP_WORD).
REQ-019 Redirects are sampled only when stall=0 and instr_valid=1; otherwise they are ignored.
REQ-020 Redirect priority: ret_en > call_en > jmp_en > skip; only the winner takes effect.
REQ-021 A jump, call or ret does the following: rom_addr<=target; instr_valid<=0 for exactly one cycle; pc_out<=target on the following advance.
REQ-022 skip does the following: rom_addr<=rom_addr+1; instr_valid<=0 for one cycle. The in-flight word is dropped.
REQ-023 Each redirect costs exactly one bubble cycle.
REQ-024 The stack has 2 entries, s0 (top) and s1, and a depth counter of 0..2.
REQ-025 call pushes pc_out+1 (mod 2048): s1<=s0; s0<=ret. Depth increments, saturating at 2. A push at depth 2 discards the old s1 and sets stack_ovf.
REQ-026 ret targets s0 and pops: s0<=s1, s1 unchanged. Depth decrements, saturating at 0. A pop at depth 0 still targets s0 and sets stack_unf.
REQ-027 stall=1 has these effects: rom_addr, pc_out, instr_valid, the stack and the flags hold. On the first stalled edge, hold_reg<=current instr and hold_valid<=1.
REQ-028 hold_valid clears on the first edge with stall=0, and that edge performs a normal advance. rom_data is then mem[rom_addr], which is the correct next word, so no word is lost or duplicated.
REQ-029 stall and a redirect in the same cycle: stall wins and the redirect is ignored. Decode re-asserts the redirect after the stall.

Reset
REQ-030 While rst=1, the outputs take these values: rom_addr=RESET_VECTOR; pc_out=RESET_VECTOR; instr_valid=0; instr=NOP_WORD; s0=s1=0; depth=0; hold_valid=0; stack_ovf=0; stack_unf=0.
REQ-031 On the first edge after rst falls, the block performs a sequential advance: instr=mem[7FF] and pc_out=7FF, then rom_addr=000.
REQ-032 rst asserted mid-redirect or mid-stall aborts the operation and forces the REQ-030 values immediately.

Verification
REQ-033 Reset release with the ROM loaded so that mem[a]=a+1 (12-bit) -> instr sequence 12'h800, 12'h001, 12'h002 with pc_out 7FF, 000, 001, one per cycle, and no bubble.
REQ-034 jmp_en with jmp_addr=11'h123, presented while pc_out=005 -> one cycle of instr_valid=0 and instr=000, then pc_out=123 and instr=mem[123].
REQ-035 call to 11'h200 at pc_out=010, then ret at pc_out=200 -> execution resumes at pc_out=011, with one bubble after the call and one after the ret.
REQ-036 Three nested calls, then three rets -> stack_ovf=1 after the 3rd call. Rets target the 3rd, 2nd and 2nd return addresses, and stack_unf=1 after the 3rd ret.
REQ-037 skip at pc_out=020 -> bubble, then pc_out=022. Also: stall held for 3 cycles at pc_out=030 -> instr and pc_out stay constant, then 031 follows with no gap or duplicate.
REQ-038 rst pulse during a stall and during a bubble -> all outputs match REQ-030 and the fetch restarts at 7FF.
